// File: rtl/axi_master_arbiter_if.sv
// One AXI4 port bundle (AR/R/AW/W/B). "master" drives requests, "slave" answers them.
interface axi_master_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [2:0]        ar_size;
  logic [1:0]        ar_burst;
  logic              ar_ready;

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic              r_ready;

  logic              aw_valid;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [2:0]        aw_size;
  logic [1:0]        aw_burst;
  logic              aw_ready;

  logic                w_valid;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic                w_ready;

  logic              b_valid;
  logic [1:0]        b_resp;
  logic              b_ready;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
    input  r_valid, r_data, r_resp, r_last, output r_ready,
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
    output r_valid, r_data, r_resp, r_last, input r_ready,
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
    input  w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_resp, input b_ready
  );
endinterface

// File: rtl/axi_master_arbiter.sv
// Two-master AXI4 arbiter: independent round-robin read and write FSMs, each holding
// its grant from address handshake through the last data beat / write response.
module axi_master_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic                  clock,
  input logic                  reset,
  axi_master_arbiter_if.slave  m0,
  axi_master_arbiter_if.slave  m1,
  axi_master_arbiter_if.master s
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

  r_state_t r_state, r_state_nx;
  w_state_t w_state, w_state_nx;
  logic     r_gnt, r_gnt_nx, r_lst, r_lst_nx;
  logic     w_gnt, w_gnt_nx, w_lst, w_lst_nx;

  // Granted master's fields, muxed once and gated by state below
  logic                ar_valid_sel, r_ready_sel, aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
  logic [ADDR_W-1:0]   ar_addr_sel, aw_addr_sel;
  logic [DATA_W-1:0]   w_data_sel;
  logic [DATA_W/8-1:0] w_strb_sel;

  assign ar_valid_sel = r_gnt ? m1.ar_valid : m0.ar_valid;
  assign ar_addr_sel  = r_gnt ? m1.ar_addr  : m0.ar_addr;
  assign r_ready_sel  = r_gnt ? m1.r_ready  : m0.r_ready;
  assign aw_valid_sel = w_gnt ? m1.aw_valid : m0.aw_valid;
  assign aw_addr_sel  = w_gnt ? m1.aw_addr  : m0.aw_addr;
  assign w_valid_sel  = w_gnt ? m1.w_valid  : m0.w_valid;
  assign w_data_sel   = w_gnt ? m1.w_data   : m0.w_data;
  assign w_strb_sel   = w_gnt ? m1.w_strb   : m0.w_strb;
  assign w_last_sel   = w_gnt ? m1.w_last   : m0.w_last;
  assign b_ready_sel  = w_gnt ? m1.b_ready  : m0.b_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
      r_lst   <= 1'b1;
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      w_lst   <= 1'b1;
    end else begin
      r_state <= r_state_nx;
      r_gnt   <= r_gnt_nx;
      r_lst   <= r_lst_nx;
      w_state <= w_state_nx;
      w_gnt   <= w_gnt_nx;
      w_lst   <= w_lst_nx;
    end
  end

  always_comb begin
    r_state_nx = r_state;
    r_gnt_nx   = r_gnt;
    r_lst_nx   = r_lst;
    s.ar_valid = 1'b0;
    s.ar_addr  = '0;
    s.ar_len   = '0;
    s.ar_size  = '0;
    s.ar_burst = '0;
    s.r_ready  = 1'b0;
    m0.ar_ready = 1'b0;
    m1.ar_ready = 1'b0;
    m0.r_valid = 1'b0;
    m0.r_data  = '0;
    m0.r_resp  = '0;
    m0.r_last  = 1'b0;
    m1.r_valid = 1'b0;
    m1.r_data  = '0;
    m1.r_resp  = '0;
    m1.r_last  = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (m0.ar_valid || m1.ar_valid) begin
          // On a tie the master that was not served last wins
          r_gnt_nx   = (m0.ar_valid && m1.ar_valid) ? ~r_lst : m1.ar_valid;
          r_state_nx = R_ADDR;
        end
      end
      R_ADDR: begin
        s.ar_valid  = ar_valid_sel;
        s.ar_addr   = ar_addr_sel;
        s.ar_len    = r_gnt ? m1.ar_len   : m0.ar_len;
        s.ar_size   = r_gnt ? m1.ar_size  : m0.ar_size;
        s.ar_burst  = r_gnt ? m1.ar_burst : m0.ar_burst;
        m0.ar_ready = !r_gnt && s.ar_ready;
        m1.ar_ready =  r_gnt && s.ar_ready;
        if (ar_valid_sel && s.ar_ready) begin
          r_state_nx = R_DATA;
          r_lst_nx   = r_gnt;
        end
      end
      R_DATA: begin
        s.r_ready = r_ready_sel;
        if (r_gnt) begin
          m1.r_valid = s.r_valid;
          m1.r_data  = s.r_data;
          m1.r_resp  = s.r_resp;
          m1.r_last  = s.r_last;
        end else begin
          m0.r_valid = s.r_valid;
          m0.r_data  = s.r_data;
          m0.r_resp  = s.r_resp;
          m0.r_last  = s.r_last;
        end
        if (s.r_valid && r_ready_sel && s.r_last) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_nx = w_state;
    w_gnt_nx   = w_gnt;
    w_lst_nx   = w_lst;
    s.aw_valid = 1'b0;
    s.aw_addr  = '0;
    s.aw_len   = '0;
    s.aw_size  = '0;
    s.aw_burst = '0;
    s.w_valid  = 1'b0;
    s.w_data   = '0;
    s.w_strb   = '0;
    s.w_last   = 1'b0;
    s.b_ready  = 1'b0;
    m0.aw_ready = 1'b0;
    m1.aw_ready = 1'b0;
    m0.w_ready  = 1'b0;
    m1.w_ready  = 1'b0;
    m0.b_valid  = 1'b0;
    m0.b_resp   = '0;
    m1.b_valid  = 1'b0;
    m1.b_resp   = '0;
    unique case (w_state)
      W_IDLE: begin
        if (m0.aw_valid || m1.aw_valid) begin
          w_gnt_nx   = (m0.aw_valid && m1.aw_valid) ? ~w_lst : m1.aw_valid;
          w_state_nx = W_ADDR;
        end
      end
      W_ADDR: begin
        s.aw_valid  = aw_valid_sel;
        s.aw_addr   = aw_addr_sel;
        s.aw_len    = w_gnt ? m1.aw_len   : m0.aw_len;
        s.aw_size   = w_gnt ? m1.aw_size  : m0.aw_size;
        s.aw_burst  = w_gnt ? m1.aw_burst : m0.aw_burst;
        m0.aw_ready = !w_gnt && s.aw_ready;
        m1.aw_ready =  w_gnt && s.aw_ready;
        if (aw_valid_sel && s.aw_ready) begin
          w_state_nx = W_DATA;
          w_lst_nx   = w_gnt;
        end
      end
      W_DATA: begin
        s.w_valid  = w_valid_sel;
        s.w_data   = w_data_sel;
        s.w_strb   = w_strb_sel;
        s.w_last   = w_last_sel;
        m0.w_ready = !w_gnt && s.w_ready;
        m1.w_ready =  w_gnt && s.w_ready;
        if (w_valid_sel && s.w_ready && w_last_sel) w_state_nx = W_RESP;
      end
      W_RESP: begin
        s.b_ready = b_ready_sel;
        if (w_gnt) begin
          m1.b_valid = s.b_valid;
          m1.b_resp  = s.b_resp;
        end else begin
          m0.b_valid = s.b_valid;
          m0.b_resp  = s.b_resp;
        end
        if (s.b_valid && b_ready_sel) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: arbitration order, burst hold, write path,
// concurrent channels, mid-burst reset and fairness under unbalanced load.
module tb_axi_master_arbiter;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axi_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  axi_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  axi_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  axi_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int b1_cnt = 0;

  always @(posedge clock) if (m1_if.b_valid && m1_if.b_ready) b1_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ar(input int m, input logic v, input logic [63:0] a, input logic [7:0] len);
    if (m == 0) begin m0_if.ar_valid = v; m0_if.ar_addr = a; m0_if.ar_len = len; end
    else        begin m1_if.ar_valid = v; m1_if.ar_addr = a; m1_if.ar_len = len; end
  endtask

  task automatic set_aw(input int m, input logic v, input logic [63:0] a);
    if (m == 0) begin m0_if.aw_valid = v; m0_if.aw_addr = a; end
    else        begin m1_if.aw_valid = v; m1_if.aw_addr = a; end
  endtask

  task automatic set_w(input int m, input logic v, input logic [63:0] d, input logic [7:0] st);
    if (m == 0) begin m0_if.w_valid = v; m0_if.w_data = d; m0_if.w_strb = st; m0_if.w_last = v; end
    else        begin m1_if.w_valid = v; m1_if.w_data = d; m1_if.w_strb = st; m1_if.w_last = v; end
  endtask

  task automatic idle_all();
    set_ar(0, 0, '0, '0); set_ar(1, 0, '0, '0);
    set_aw(0, 0, '0);     set_aw(1, 0, '0);
    set_w(0, 0, '0, '0);  set_w(1, 0, '0, '0);
    m0_if.ar_size = 3'd3; m0_if.ar_burst = 2'd1; m1_if.ar_size = 3'd3; m1_if.ar_burst = 2'd1;
    m0_if.aw_len = '0; m0_if.aw_size = 3'd3; m0_if.aw_burst = 2'd1;
    m1_if.aw_len = '0; m1_if.aw_size = 3'd3; m1_if.aw_burst = 2'd1;
    m0_if.r_ready = 1'b1; m1_if.r_ready = 1'b1; m0_if.b_ready = 1'b1; m1_if.b_ready = 1'b1;
    s_if.ar_ready = 1'b0; s_if.aw_ready = 1'b0; s_if.w_ready = 1'b0;
    s_if.r_valid = 1'b0; s_if.r_data = '0; s_if.r_resp = '0; s_if.r_last = 1'b0;
    s_if.b_valid = 1'b0; s_if.b_resp = '0;
  endtask

  // From R_ADDR with master m granted: address handshake, then one last beat
  task automatic rd_finish(input int m, input logic [63:0] d);
    s_if.ar_ready = 1'b1;
    tick();
    set_ar(m, 0, '0, '0);
    s_if.ar_ready = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_data = d; s_if.r_last = 1'b1;
    tick();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
  endtask

  // From W_ADDR with master m granted: AW, single W beat, B
  task automatic wr_finish(input int m);
    s_if.aw_ready = 1'b1;
    tick();
    set_aw(m, 0, '0);
    s_if.aw_ready = 1'b0;
    set_w(m, 1, 64'h77, 8'hff);
    s_if.w_ready = 1'b1;
    tick();
    set_w(m, 0, '0, '0);
    s_if.w_ready = 1'b0;
    s_if.b_valid = 1'b1;
    tick();
    s_if.b_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [63:0] d;
    // Reset state, with a request present that must be ignored
    reset = 1'b1;
    idle_all();
    set_ar(0, 1, 64'h8000_0000, 8'd0);
    tick(); tick();
    chk("rst_s_ar_valid", s_if.ar_valid, 0);
    chk("rst_s_ar_addr", s_if.ar_addr, 0);
    chk("rst_m0_ar_ready", m0_if.ar_ready, 0);
    chk("rst_s_r_ready", s_if.r_ready, 0);
    chk("rst_s_aw_valid", s_if.aw_valid, 0);
    chk("rst_m0_w_ready", m0_if.w_ready, 0);

    // Tie after reset goes to m0, then m1, then m0 again
    reset = 1'b0;
    set_ar(1, 1, 64'ha000_0048, 8'd0);
    #1 chk("arb_cycle_no_valid", s_if.ar_valid, 0);
    tick();
    chk("tie1_addr_m0", s_if.ar_addr, 64'h8000_0000);
    s_if.ar_ready = 1'b1;
    #1 chk("tie1_m0_ar_ready", m0_if.ar_ready, 1);
    chk("tie1_m1_ar_ready", m1_if.ar_ready, 0);
    tick();
    set_ar(0, 0, '0, '0);
    s_if.ar_ready = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_data = 64'h1111; s_if.r_last = 1'b1;
    #1 chk("tie1_r_data_m0", m0_if.r_data, 64'h1111);
    chk("tie1_r_valid_m1", m1_if.r_valid, 0);
    tick();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    #1 chk("switch_bubble", s_if.ar_valid, 0);
    tick();
    chk("tie1_then_m1", s_if.ar_addr, 64'ha000_0048);
    rd_finish(1, 64'h2222);
    set_ar(0, 1, 64'h8000_0100, 8'd0);
    set_ar(1, 1, 64'ha000_0100, 8'd3);
    tick();
    chk("tie2_addr_m0", s_if.ar_addr, 64'h8000_0100);
    rd_finish(0, 64'h3333);

    // m1 burst of 4 with a 2-cycle stall; m0 waits the whole burst
    tick();
    chk("burst_grant_m1", s_if.ar_len, 64'd3);
    s_if.ar_ready = 1'b1;
    tick();
    set_ar(1, 0, '0, '0);
    s_if.ar_ready = 1'b0;
    set_ar(0, 1, 64'h8000_0200, 8'd0);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        s_if.r_valid = 1'b0;
        for (int j = 0; j < 2; j++) begin
          #1 chk("burst_stall_m1_valid", m1_if.r_valid, 0);
          tick();
        end
      end
      d = 64'hd0 + 64'(k);
      s_if.r_valid = 1'b1; s_if.r_data = d; s_if.r_last = (k == 3);
      #1 chk("burst_m1_data", m1_if.r_data, d);
      chk("burst_m0_r_valid", m0_if.r_valid, 0);
      chk("burst_m0_not_granted", s_if.ar_valid, 0);
      tick();
    end
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    #1 chk("burst_bubble", s_if.ar_valid, 0);
    tick();
    chk("burst_then_m0", s_if.ar_addr, 64'h8000_0200);
    rd_finish(0, 64'h4444);

    // m1 write with AW stalled 3 cycles and B delayed 5; m0 queues behind it
    set_aw(1, 1, 64'ha000_03f8);
    set_w(1, 1, 64'h41, 8'h01);
    #1 chk("wr_arb_no_valid", s_if.aw_valid, 0);
    tick();
    set_aw(0, 1, 64'h8000_0300);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wr_aw_addr", s_if.aw_addr, 64'ha000_03f8);
      chk("wr_m0_aw_ready", m0_if.aw_ready, 0);
      chk("wr_no_w_yet", s_if.w_valid, 0);
      tick();
    end
    s_if.aw_ready = 1'b1;
    #1 chk("wr_m1_aw_ready", m1_if.aw_ready, 1);
    chk("wr_m0_aw_ready_hs", m0_if.aw_ready, 0);
    tick();
    set_aw(1, 0, '0);
    s_if.aw_ready = 1'b0;
    s_if.w_ready = 1'b1;
    #1 chk("wr_w_data", s_if.w_data, 64'h41);
    chk("wr_w_strb", s_if.w_strb, 64'h01);
    chk("wr_m0_w_ready", m0_if.w_ready, 0);
    tick();
    set_w(1, 0, '0, '0);
    s_if.w_ready = 1'b0;
    b0 = b1_cnt;
    for (int i = 0; i < 5; i++) begin
      #1 chk("wr_b_wait", m1_if.b_valid, 0);
      chk("wr_resp_m0_aw_ready", m0_if.aw_ready, 0);
      tick();
    end
    s_if.b_valid = 1'b1;
    #1 chk("wr_m1_b_valid", m1_if.b_valid, 1);
    chk("wr_m0_b_valid", m0_if.b_valid, 0);
    tick();
    s_if.b_valid = 1'b0;
    #1 chk("wr_b_once", 64'(b1_cnt - b0), 1);
    tick();
    chk("wr_then_m0", s_if.aw_addr, 64'h8000_0300);
    wr_finish(0);

    // Concurrent m0 read and m1 write
    set_ar(0, 1, 64'h8000_1000, 8'd0);
    set_aw(1, 1, 64'ha000_0000);
    set_w(1, 1, 64'h5555, 8'hff);
    tick();
    chk("conc_ar_addr", s_if.ar_addr, 64'h8000_1000);
    chk("conc_aw_addr", s_if.aw_addr, 64'ha000_0000);
    s_if.ar_ready = 1'b1; s_if.aw_ready = 1'b1;
    tick();
    set_ar(0, 0, '0, '0); set_aw(1, 0, '0);
    s_if.ar_ready = 1'b0; s_if.aw_ready = 1'b0;
    s_if.r_valid = 1'b1; s_if.r_data = 64'h6666; s_if.r_last = 1'b1;
    s_if.w_ready = 1'b1;
    #1 chk("conc_m0_r_data", m0_if.r_data, 64'h6666);
    chk("conc_s_w_data", s_if.w_data, 64'h5555);
    tick();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0; s_if.w_ready = 1'b0;
    set_w(1, 0, '0, '0);
    s_if.b_valid = 1'b1;
    #1 chk("conc_m1_b_valid", m1_if.b_valid, 1);
    tick();
    s_if.b_valid = 1'b0;

    // Reset in the middle of a len=7 burst
    set_ar(0, 1, 64'h8000_2000, 8'd7);
    tick();
    s_if.ar_ready = 1'b1;
    tick();
    set_ar(0, 0, '0, '0);
    s_if.ar_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_if.r_valid = 1'b1; s_if.r_data = 64'h700 + 64'(k); s_if.r_last = 1'b0;
      tick();
    end
    #1 chk("mid_burst_r_valid", m0_if.r_valid, 1);
    reset = 1'b1;
    set_ar(1, 1, 64'ha000_0800, 8'd0);
    tick();
    s_if.r_valid = 1'b0;
    #1 chk("rst_mid_m0_r_valid", m0_if.r_valid, 0);
    chk("rst_mid_s_r_ready", s_if.r_ready, 0);
    chk("rst_mid_s_ar_valid", s_if.ar_valid, 0);
    reset = 1'b0;
    #1 chk("post_rst_arb_cycle", s_if.ar_valid, 0);
    tick();
    chk("post_rst_grant_m1", s_if.ar_addr, 64'ha000_0800);
    rd_finish(1, 64'h8888);

    // m0 requests continuously, m1 once: m1 wins the next arbitration
    set_ar(0, 1, 64'h8000_3000, 8'd0);
    tick();
    s_if.ar_ready = 1'b1;
    tick();
    s_if.ar_ready = 1'b0;
    set_ar(0, 1, 64'h8000_3040, 8'd0);
    set_ar(1, 1, 64'ha000_0c00, 8'd0);
    s_if.r_valid = 1'b1; s_if.r_data = 64'h9999; s_if.r_last = 1'b1;
    tick();
    s_if.r_valid = 1'b0; s_if.r_last = 1'b0;
    tick();
    chk("fair_m1_granted", s_if.ar_addr, 64'ha000_0c00);
    s_if.ar_ready = 1'b1;
    #1 chk("fair_m0_ar_ready", m0_if.ar_ready, 0);
    rd_finish(1, 64'haaaa);
    tick();
    chk("fair_m0_next", s_if.ar_addr, 64'h8000_3040);
    rd_finish(0, 64'hbbbb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
